// File: rtl/vec_main_decoder.sv
// Registered multi-beat main decoder for the vector PE: one opcode per handshake in,
// a stream of control micro-ops out, with memory ops expanded into VLEN/MEM_W beats.
module vec_main_decoder #(
  parameter int VLEN  = 256,
  parameter int MEM_W = 32,
  localparam int BEATS = VLEN / MEM_W,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    Op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          RegWrite,
  output logic          ALUSrc,
  output logic          MemWrite,
  output logic          ResultSrc,
  output logic          Branch,
  output logic          UseImm,
  output logic [1:0]    ImmSrc,
  output logic [1:0]    ALUOp,
  output logic [BW-1:0] Beat,
  output logic          Last,
  output logic          Illegal
);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic       use_imm;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam bit            HAS_BURST = (BEATS > 1);

  state_t        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d, dec;
  logic          multi;
  logic          accept;
  logic [BW-1:0] beat_q, beat_d, beat_inc;

  assign in_ready = !flush && (state_q == IDLE || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;
  assign beat_inc = beat_q + BW'(1);

  always_comb begin
    dec   = '0;
    multi = 1'b0;
    case (Op)
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 1'b1;
        multi          = 1'b1;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 2'b01;
        multi         = 1'b1;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.use_imm   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      7'b1100011: begin
        dec.branch  = 1'b1;
        dec.imm_src = 2'b10;
        dec.alu_op  = 2'b01;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Flush wins over accept; with no accept, a consumed last beat drains to IDLE
  // and clears the controls so an idle output bundle is all zeros.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    beat_d  = beat_q;
    if (flush) begin
      state_d = IDLE;
      ctrl_d  = '0;
      beat_d  = '0;
    end else if (accept) begin
      ctrl_d  = dec;
      beat_d  = '0;
      state_d = (multi && HAS_BURST) ? BURST : HOLD;
    end else begin
      case (state_q)
        BURST: if (out_ready) begin
          beat_d = beat_inc;
          if (beat_inc == LAST_BEAT) state_d = HOLD;
        end
        HOLD: if (out_ready) begin
          state_d = IDLE;
          ctrl_d  = '0;
          beat_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      beat_q  <= beat_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign Last      = (state_q == HOLD);
  assign Beat      = beat_q;
  assign RegWrite  = ctrl_q.reg_write;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign ResultSrc = ctrl_q.result_src;
  assign Branch    = ctrl_q.branch;
  assign UseImm    = ctrl_q.use_imm;
  assign ImmSrc    = ctrl_q.imm_src;
  assign ALUOp     = ctrl_q.alu_op;
  assign Illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_vec_main_decoder.sv
// Bench for vec_main_decoder: directed tables and sequences, then randomized traffic
// compared against an instruction-level reference model.
module tb_vec_main_decoder;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, UseImm, ImmSrc, ALUOp, Illegal}
  localparam logic [10:0] C_R     = 11'b1_0_0_0_0_0_00_10_0;
  localparam logic [10:0] C_I     = 11'b1_1_0_0_0_1_00_10_0;
  localparam logic [10:0] C_BEQ   = 11'b0_0_0_0_1_0_10_01_0;
  localparam logic [10:0] C_LOAD  = 11'b1_1_0_1_0_0_00_00_0;
  localparam logic [10:0] C_STORE = 11'b0_1_1_0_0_0_01_00_0;
  localparam logic [10:0] C_ILL   = 11'b0_0_0_0_0_0_00_00_1;

  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, in_valid1 = 1'b0;
  logic [6:0] op = '0, op1 = '0;

  logic in_ready, out_valid, reg_write, alu_src, mem_write, result_src, branch, use_imm, last, illegal;
  logic [1:0] imm_src, alu_op;
  logic [2:0] beat;
  logic in_ready1, out_valid1, reg_write1, alu_src1, mem_write1, result_src1, branch1, use_imm1, last1, illegal1;
  logic [1:0] imm_src1, alu_op1;
  logic [0:0] beat1;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_main_decoder #(.VLEN(256), .MEM_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .Op(op),
    .out_valid(out_valid), .out_ready(out_ready), .RegWrite(reg_write), .ALUSrc(alu_src),
    .MemWrite(mem_write), .ResultSrc(result_src), .Branch(branch), .UseImm(use_imm),
    .ImmSrc(imm_src), .ALUOp(alu_op), .Beat(beat), .Last(last), .Illegal(illegal)
  );

  vec_main_decoder #(.VLEN(32), .MEM_W(32)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1), .Op(op1),
    .out_valid(out_valid1), .out_ready(out_ready), .RegWrite(reg_write1), .ALUSrc(alu_src1),
    .MemWrite(mem_write1), .ResultSrc(result_src1), .Branch(branch1), .UseImm(use_imm1),
    .ImmSrc(imm_src1), .ALUOp(alu_op1), .Beat(beat1), .Last(last1), .Illegal(illegal1)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [10:0] ctrl;
  } vec_t;

  // Reference decode built from per-opcode class flags rather than a case table.
  function automatic logic [10:0] refCtrl(input logic [6:0] o);
    bit ld, st, r, i, b;
    ld = (o == OP_LOAD);
    st = (o == OP_STORE);
    r  = (o == OP_R);
    i  = (o == OP_I);
    b  = (o == OP_BEQ);
    return {ld | r | i, ld | st | i, st, ld, b, i, b, st, r | i, b, !(ld | st | r | i | b)};
  endfunction

  task automatic applyStimulus(input bit r, input bit iv, input logic [6:0] o,
                               input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    op        = o;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input bit sel1, input bit exp_valid,
                             input logic [10:0] exp_ctrl, input logic [2:0] exp_beat,
                             input bit exp_last, input bit chk_ready, input bit exp_ready);
    logic        act_valid, act_last, act_ready;
    logic [10:0] act_ctrl;
    logic [2:0]  act_beat;
    @(negedge clk);
    if (sel1) begin
      act_valid = out_valid1;
      act_ctrl  = {reg_write1, alu_src1, mem_write1, result_src1, branch1, use_imm1,
                   imm_src1, alu_op1, illegal1};
      act_beat  = {2'b00, beat1};
      act_last  = last1;
      act_ready = in_ready1;
    end else begin
      act_valid = out_valid;
      act_ctrl  = {reg_write, alu_src, mem_write, result_src, branch, use_imm,
                   imm_src, alu_op, illegal};
      act_beat  = beat;
      act_last  = last;
      act_ready = in_ready;
    end
    tests++;
    if (act_valid !== exp_valid || act_ctrl !== exp_ctrl || act_beat !== exp_beat ||
        act_last !== exp_last || (chk_ready && act_ready !== exp_ready)) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%b ctrl=%b beat=%0d last=%b ready=%b, want valid=%b ctrl=%b beat=%0d last=%b ready=%b",
               name, act_valid, act_ctrl, act_beat, act_last, act_ready,
               exp_valid, exp_ctrl, exp_beat, exp_last, chk_ready ? exp_ready : act_ready);
    end
  endtask

  initial begin
    vec_t tbl[6];
    bit   m_busy;
    logic [6:0] m_op;
    int   m_beat, m_nbeats;

    tbl[0] = '{"i_alu",  OP_I,      C_I};
    tbl[1] = '{"beq",    OP_BEQ,    C_BEQ};
    tbl[2] = '{"r_type", OP_R,      C_R};
    tbl[3] = '{"ill_7f", 7'h7f,     C_ILL};
    tbl[4] = '{"ill_00", 7'h00,     C_ILL};
    tbl[5] = '{"ill_37", 7'b0110111, C_ILL};

    // Reset held with a valid R-type presented; nothing may escape.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, OP_R, 1, 0);
      checkOutput("reset_hold", 0, 0, '0, 0, 0, 0, 0);
    end
    applyStimulus(0, 1, OP_R, 1, 0);
    checkOutput("reset_release", 0, 0, '0, 0, 0, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("reset_first_op", 0, 1, C_R, 0, 1, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("reset_drain", 0, 0, '0, 0, 0, 1, 1);

    // Back-to-back single-beat ops, one per cycle.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, tbl[k].op, 1, 0);
      if (k == 0) checkOutput("stream_start", 0, 0, '0, 0, 0, 1, 1);
      else        checkOutput(tbl[k-1].name, 0, 1, tbl[k-1].ctrl, 0, 1, 1, 1);
    end
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput(tbl[5].name, 0, 1, tbl[5].ctrl, 0, 1, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("stream_idle", 0, 0, '0, 0, 0, 1, 1);

    // Unstalled load burst.
    applyStimulus(0, 1, OP_LOAD, 1, 0);
    checkOutput("load_accept", 0, 0, '0, 0, 0, 1, 1);
    for (int b = 0; b < BEATS; b++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput($sformatf("load_beat%0d", b), 0, 1, C_LOAD, 3'(b), b == BEATS - 1, 1, b == BEATS - 1);
    end
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("load_idle", 0, 0, '0, 0, 0, 1, 1);

    // Store with a four-cycle stall at beat 3.
    applyStimulus(0, 1, OP_STORE, 1, 0);
    checkOutput("store_accept", 0, 0, '0, 0, 0, 1, 1);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput($sformatf("store_beat%0d", b), 0, 1, C_STORE, 3'(b), 0, 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, OP_R, 0, 0);
      checkOutput("store_stall", 0, 1, C_STORE, 3, 0, 1, 0);
    end
    for (int b = 3; b < BEATS; b++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput($sformatf("store_resume%0d", b), 0, 1, C_STORE, 3'(b), b == BEATS - 1, 1, b == BEATS - 1);
    end
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("store_idle", 0, 0, '0, 0, 0, 1, 1);

    // Load flushed at beat 2 while a new op is offered; the offer is dropped.
    applyStimulus(0, 1, OP_LOAD, 1, 0);
    checkOutput("flush_accept", 0, 0, '0, 0, 0, 1, 1);
    for (int b = 0; b < 2; b++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput($sformatf("flush_beat%0d", b), 0, 1, C_LOAD, 3'(b), 0, 1, 0);
    end
    applyStimulus(0, 1, OP_R, 1, 1);
    checkOutput("flush_cycle", 0, 1, C_LOAD, 2, 0, 1, 0);
    applyStimulus(0, 1, OP_I, 1, 0);
    checkOutput("flush_after", 0, 0, '0, 0, 0, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("flush_next_op", 0, 1, C_I, 0, 1, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("flush_idle", 0, 0, '0, 0, 0, 1, 1);

    // Single-beat memory ops on the VLEN == MEM_W instance.
    applyStimulus(0, 0, '0, 1, 0);
    in_valid1 = 1'b1;
    op1       = OP_STORE;
    checkOutput("deg_idle", 1, 0, '0, 0, 0, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    in_valid1 = 1'b1;
    op1       = OP_LOAD;
    checkOutput("deg_store", 1, 1, C_STORE, 0, 1, 1, 1);
    applyStimulus(0, 0, '0, 0, 0);
    in_valid1 = 1'b0;
    checkOutput("deg_load", 1, 1, C_LOAD, 0, 1, 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("deg_load_held", 1, 1, C_LOAD, 0, 1, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("deg_drain", 1, 0, '0, 0, 0, 1, 1);

    // Randomized traffic against the instruction-level model.
    m_busy = 0; m_op = '0; m_beat = 0; m_nbeats = 1;
    for (int n = 0; n < 800; n++) begin
      bit r, iv, ordy, fl, m_last, exp_ready;
      logic [6:0] o;
      r    = (n == 0) || ($urandom_range(0, 63) == 0);
      iv   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 3) != 0;
      fl   = $urandom_range(0, 15) == 0;
      case ($urandom_range(0, 7))
        0: o = OP_LOAD;
        1: o = OP_STORE;
        2: o = OP_R;
        3: o = OP_I;
        4: o = OP_BEQ;
        default: o = 7'($urandom);
      endcase
      applyStimulus(r, iv, o, ordy, fl);
      m_last    = m_busy && (m_beat == m_nbeats - 1);
      exp_ready = !fl && (!m_busy || (m_last && ordy));
      checkOutput("random", 0, m_busy, m_busy ? refCtrl(m_op) : 11'b0,
                  m_busy ? 3'(m_beat) : 3'b0, m_last, 1, exp_ready);
      if (r || fl) begin
        m_busy = 0;
      end else if (iv && exp_ready) begin
        m_busy   = 1;
        m_op     = o;
        m_beat   = 0;
        m_nbeats = (o == OP_LOAD || o == OP_STORE) ? BEATS : 1;
      end else if (m_busy && ordy) begin
        if (m_last) m_busy = 0;
        else        m_beat++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/vec_main_decoder.md
# vec_main_decoder

Registered, multi-beat successor to the combinational main decoder for the 256-bit vector processing element. It accepts one opcode per valid/ready handshake, decodes it into the standard control bundle, and emits it as a registered micro-op stream toward execute. Vector load/store instructions expand into VLEN/MEM_W beats, each carrying a beat index. Illegal opcodes are flagged rather than silently decoded as no-ops.

## Interface
- VLEN, 256, vector register width in bits
- MEM_W, 32, memory datapath width in bits; BEATS = VLEN/MEM_W, a power of two ≥ 1
- BW (localparam), max(1, clog2(BEATS)), beat index width
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  Op is valid
- in_ready  out  1  decoder accepts Op this cycle
- Op  in  7  instruction opcode field
- out_valid  out  1  micro-op outputs are valid
- out_ready  in  1  downstream consumes the micro-op this cycle
- RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, UseImm  out  1 each  control signals
- ImmSrc  out  2  immediate format select
- ALUOp  out  2  ALU decoder class
- Beat  out  BW  beat index of the current micro-op
- Last  out  1  final micro-op of the instruction
- Illegal  out  1  opcode not recognised

## Operation
- Decode map. Any signal not listed is 0.
  - 0000011 load: RegWrite, ALUSrc and ResultSrc are 1; ImmSrc=00; ALUOp=00; multi-beat.
  - 0100011 store: MemWrite and ALUSrc are 1; ImmSrc=01; ALUOp=00; multi-beat.
  - 0110011 R-type: RegWrite=1; ALUOp=10.
  - 0010011 I-ALU: RegWrite, ALUSrc and UseImm are 1; ALUOp=10.
  - 1100011 beq: Branch=1; ImmSrc=10; ALUOp=01.
  - Any other opcode: all controls 0, Illegal=1; single beat.
- FSM states:
  - IDLE: no micro-op held; out_valid=0.
  - HOLD: single-beat or last-beat micro-op held; Last=1.
  - BURST: memory micro-op held with Beat < BEATS-1; Last=0.
- in_ready = !flush && (state==IDLE || (state==HOLD && out_ready)).
- Accept (in_valid && in_ready):
  - Controls are decoded and registered; Beat=0; out_valid=1.
  - Next state is BURST if the opcode is multi-beat and BEATS>1, otherwise HOLD.
- In BURST, when out_ready=1: Beat increments and all controls are held. Entering Beat=BEATS-1 sets Last=1 and moves to HOLD.
- In HOLD, when out_ready=1 and there is no new accept: go to IDLE with out_valid=0.
- Stall: while out_valid && !out_ready, every output is held bit-stable.
- flush:
  - Clears out_valid and Last.
  - Forces IDLE, which aborts any burst mid-instruction.
  - Control outputs return to 0.
  - No input is accepted that cycle.
- rst overrides flush.
- Reset values:
  - out_valid, Last, Illegal, Beat and all control outputs are 0.
  - State is IDLE.
  - in_ready is 1 in the first cycle after rst deasserts.

## Timing
- Latency: Op accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one single-beat instruction per cycle when out_ready is held high (back-to-back through HOLD).
- A memory instruction occupies BEATS consecutive output cycles when unstalled. The next instruction can be accepted in the cycle its Last beat is consumed.
- BEATS=1 (VLEN==MEM_W): memory ops go directly to HOLD with Last=1 and Beat=0, and BURST is never entered.
- in_ready has no combinational dependence on in_valid. Its only combinational path is through out_ready and flush.
- Simultaneous flush and in_valid: the input is dropped and in_ready is 0.
- rst is asserted mid-burst: the reset values apply on the next edge.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 and Op=0110011. Require out_valid=0 and all outputs 0 throughout. After release, in_ready=1, and the R-type micro-op appears one cycle later with RegWrite=1, ALUOp=10, Last=1.
- Throughput: stream I-ALU, beq, R-type with out_ready=1. Require three consecutive valid cycles:
  - UseImm=1, ALUSrc=1
  - Branch=1, ImmSrc=10, ALUOp=01
  - RegWrite=1, ALUOp=10
- Memory burst (VLEN=256, MEM_W=32): load with out_ready=1. Require 8 beats with Beat=0..7 and ResultSrc=1 on every beat. Last=1 only on Beat=7. in_ready=0 during Beats 0..6.
- Backpressure: store, with out_ready dropped at Beat=3 for 4 cycles. Require Beat=3, MemWrite=1, ImmSrc=01 stable, then the burst resumes at 4..7.
- Illegal and flush:
  - Opcode 1111111 gives one micro-op with Illegal=1, all controls 0, Last=1.
  - A load flushed at Beat=2 gives out_valid=0 the next cycle; the subsequent Op is accepted cleanly.
- Degenerate case: VLEN=32, MEM_W=32. Store gives one micro-op with Beat=0, Last=1.
